// File: rtl/lfsr_pkg.sv
// Shared types for the LFSR batch sequencer: FSM states, batch modes and step ops.
// The SEQ_WATCHDOG_EN build option is handled in lfsr_batch_sequencer.sv.
package lfsr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_ACK   = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_WAIT_DRAIN = 3'd4,
    ST_GAP        = 3'd5,
    ST_ABORT_WAIT = 3'd6,
    ST_DONE       = 3'd7
  } seq_state_e;

  localparam logic [1:0] SEQ_MODE_PULSE = 2'b00;
  localparam logic [1:0] SEQ_MODE_SHIFT = 2'b01;
  localparam logic [1:0] SEQ_MODE_P_S   = 2'b10;
  localparam logic [1:0] SEQ_MODE_S_P   = 2'b11;

  typedef enum logic {
    SEQ_OP_PULSE = 1'b0,
    SEQ_OP_SHIFT = 1'b1
  } seq_op_e;

  function automatic seq_op_e seq_first_op(input logic [1:0] mode);
    seq_op_e op;
    case (mode)
      SEQ_MODE_SHIFT, SEQ_MODE_S_P: op = SEQ_OP_SHIFT;
      SEQ_MODE_PULSE, SEQ_MODE_P_S: op = SEQ_OP_PULSE;
      default:                      op = SEQ_OP_PULSE;
    endcase
    return op;
  endfunction

  // Modes 10/11 run two ops per iteration.
  function automatic logic seq_two_ops(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic seq_op_e seq_other_op(input seq_op_e op);
    return (op == SEQ_OP_PULSE) ? SEQ_OP_SHIFT : SEQ_OP_PULSE;
  endfunction

  function automatic logic seq_is_watched(input seq_state_e st);
    return (st == ST_WAIT_ACK) || (st == ST_WAIT_DONE) || (st == ST_ABORT_WAIT);
  endfunction

endpackage

// File: rtl/lfsr_batch_sequencer_if.sv
// Host-side and controller-side signals of the batch sequencer.
// master = host/controller environment, slave = the sequencer itself.
interface lfsr_batch_sequencer_if #(
  parameter int ITER_W = 16,
  parameter int GAP_W  = 8
);
  logic              start;
  logic              abort;
  logic [ITER_W-1:0] num_iter;
  logic [1:0]        mode;
  logic [GAP_W-1:0]  gap_cycles;
  logic              ctrl_idle;
  logic              out_fifo_empty;
  logic              lfsr_shift_trigger;
  logic              lfsr_pulse_trigger;
  logic              busy;
  logic              done;
  logic              aborted;
  logic              seq_error;
  logic [ITER_W-1:0] iter_count;

  modport master (
    output start, abort, num_iter, mode, gap_cycles, ctrl_idle, out_fifo_empty,
    input  lfsr_shift_trigger, lfsr_pulse_trigger, busy, done, aborted, seq_error, iter_count
  );

  modport slave (
    input  start, abort, num_iter, mode, gap_cycles, ctrl_idle, out_fifo_empty,
    output lfsr_shift_trigger, lfsr_pulse_trigger, busy, done, aborted, seq_error, iter_count
  );
endinterface

// File: rtl/seq_watchdog.sv
// Load/enable down-counter; expired is high while enabled and the count has run out.
// A load gives LOAD_VAL enabled cycles before expiry.
module seq_watchdog #(
  parameter int LOAD_VAL = 1023,
  parameter int CNT_W    = $clog2(LOAD_VAL + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(LOAD_VAL - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == '0);
endmodule

// File: rtl/lfsr_batch_sequencer.sv
// Runs a host-programmed batch of pulse/shift iterations on the LFSR controller.
// Define SEQ_WATCHDOG_EN to bound the controller waits with an ACK_TIMEOUT watchdog.
module lfsr_batch_sequencer
  import lfsr_pkg::*;
#(
  parameter int ITER_W = 16,
  parameter int GAP_W  = 8
`ifdef SEQ_WATCHDOG_EN
  , parameter int ACK_TIMEOUT = 1023
`endif
) (
  input logic                   clk,
  input logic                   rst,
  lfsr_batch_sequencer_if.slave bus
);

  seq_state_e        state_q,      state_d;
  logic [1:0]        mode_q,       mode_d;
  logic [ITER_W-1:0] num_iter_q,   num_iter_d;
  logic [GAP_W-1:0]  gap_q,        gap_d;
  logic [GAP_W-1:0]  gap_cnt_q,    gap_cnt_d;
  seq_op_e           step_q,       step_d;
  logic              second_q,     second_d;
  logic [ITER_W-1:0] iter_count_q, iter_count_d;
  logic              busy_q,       busy_d;
  logic              done_q,       done_d;
  logic              aborted_q,    aborted_d;
  logic              seq_error_q,  seq_error_d;
  logic              shift_trig_q, shift_trig_d;
  logic              pulse_trig_q, pulse_trig_d;

  logic [ITER_W-1:0] iter_next;
  logic              last_iter;
  logic              abort_req;
  logic              wd_expired;

  assign iter_next = iter_count_q + ITER_W'(1);
  assign last_iter = (iter_count_q >= num_iter_q) || (iter_next == num_iter_q);
  assign abort_req = bus.abort &&
                     (state_q inside {ST_ISSUE, ST_WAIT_ACK, ST_WAIT_DONE, ST_WAIT_DRAIN, ST_GAP});

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    num_iter_d   = num_iter_q;
    gap_d        = gap_q;
    gap_cnt_d    = gap_cnt_q;
    step_d       = step_q;
    second_d     = second_q;
    iter_count_d = iter_count_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    aborted_d    = aborted_q;
    seq_error_d  = seq_error_q;
    shift_trig_d = 1'b0;
    pulse_trig_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mode_d       = bus.mode;
          num_iter_d   = bus.num_iter;
          gap_d        = bus.gap_cycles;
          iter_count_d = '0;
          aborted_d    = 1'b0;
          seq_error_d  = 1'b0;
          busy_d       = 1'b1;
          step_d       = seq_first_op(bus.mode);
          second_d     = 1'b0;
          state_d      = (bus.num_iter == '0) ? ST_DONE : ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // The drain check comes first so a shift never overruns unread data.
        if ((step_q == SEQ_OP_SHIFT) && !bus.out_fifo_empty) begin
          state_d = ST_WAIT_DRAIN;
        end else if (bus.ctrl_idle) begin
          pulse_trig_d = (step_q == SEQ_OP_PULSE);
          shift_trig_d = (step_q == SEQ_OP_SHIFT);
          state_d      = ST_WAIT_ACK;
        end
      end

      ST_WAIT_DRAIN: begin
        if (bus.out_fifo_empty) begin
          state_d = ST_ISSUE;
        end
      end

      ST_WAIT_ACK: begin
        if (!bus.ctrl_idle) begin
          state_d = ST_WAIT_DONE;
        end else if (wd_expired) begin
          seq_error_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_WAIT_DONE: begin
        if (bus.ctrl_idle) begin
          if (seq_two_ops(mode_q) && !second_q) begin
            second_d = 1'b1;
            step_d   = seq_other_op(step_q);
            state_d  = ST_ISSUE;
          end else begin
            second_d = 1'b0;
            step_d   = seq_first_op(mode_q);
            if (iter_count_q < num_iter_q) begin
              iter_count_d = iter_next;
            end
            if (last_iter) begin
              state_d = ST_DONE;
            end else if (gap_q == '0) begin
              state_d = ST_ISSUE;
            end else begin
              gap_cnt_d = gap_q - GAP_W'(1);
              state_d   = ST_GAP;
            end
          end
        end else if (wd_expired) begin
          seq_error_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_ISSUE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      ST_ABORT_WAIT: begin
        if (bus.ctrl_idle) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (wd_expired) begin
          seq_error_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An iteration that completes in the abort cycle still counts.
    if (abort_req) begin
      state_d      = ST_ABORT_WAIT;
      pulse_trig_d = 1'b0;
      shift_trig_d = 1'b0;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  logic wd_load;
  logic wd_en;

  assign wd_en   = seq_is_watched(state_q);
  assign wd_load = (state_d != state_q) && seq_is_watched(state_d);

  seq_watchdog #(
    .LOAD_VAL (ACK_TIMEOUT)
  ) u_seq_watchdog (
    .clk     (clk),
    .rst     (rst),
    .load    (wd_load),
    .en      (wd_en),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= '0;
      num_iter_q   <= '0;
      gap_q        <= '0;
      gap_cnt_q    <= '0;
      step_q       <= SEQ_OP_PULSE;
      second_q     <= 1'b0;
      iter_count_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      seq_error_q  <= 1'b0;
      shift_trig_q <= 1'b0;
      pulse_trig_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      num_iter_q   <= num_iter_d;
      gap_q        <= gap_d;
      gap_cnt_q    <= gap_cnt_d;
      step_q       <= step_d;
      second_q     <= second_d;
      iter_count_q <= iter_count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      seq_error_q  <= seq_error_d;
      shift_trig_q <= shift_trig_d;
      pulse_trig_q <= pulse_trig_d;
    end
  end

  assign bus.lfsr_shift_trigger = shift_trig_q;
  assign bus.lfsr_pulse_trigger = pulse_trig_q;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
  assign bus.aborted            = aborted_q;
  assign bus.seq_error          = seq_error_q;
  assign bus.iter_count         = iter_count_q;

endmodule

// File: tb/tb_lfsr_batch_sequencer.sv
// Scoreboard bench for lfsr_batch_sequencer with controller and pipe-out FIFO models.
// Build with +define+SEQ_WATCHDOG_EN to exercise the watchdog timeout path.
module tb_lfsr_batch_sequencer;
  import lfsr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lfsr_batch_sequencer_if #(.ITER_W(16), .GAP_W(8)) bus ();

`ifdef SEQ_WATCHDOG_EN
  lfsr_batch_sequencer #(.ITER_W(16), .GAP_W(8), .ACK_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`else
  lfsr_batch_sequencer #(.ITER_W(16), .GAP_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  byte exp_q[$];
  int  p_cnt, s_cnt, done_cnt, done_cyc, start_cyc;
  int  last_trig_cyc = -1;
  int  ctrl_len = 10;
  int  fifo_len = 0;
  bit  hang = 1'b0;
  bit  chk_spacing = 1'b0;
  int  busy_cnt, drain_cnt;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Controller: leaves idle one cycle after a trigger, busy for ctrl_len cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ctrl_idle <= 1'b1;
      busy_cnt      <= 0;
    end else if (bus.ctrl_idle) begin
      if ((bus.lfsr_pulse_trigger || bus.lfsr_shift_trigger) && !hang) begin
        bus.ctrl_idle <= 1'b0;
        busy_cnt      <= ctrl_len - 1;
      end
    end else if (busy_cnt == 0) begin
      bus.ctrl_idle <= 1'b1;
    end else begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // Pipe-out FIFO: holds data for fifo_len cycles after each shift.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_fifo_empty <= 1'b1;
      drain_cnt          <= 0;
    end else if (bus.lfsr_shift_trigger && fifo_len > 0) begin
      bus.out_fifo_empty <= 1'b0;
      drain_cnt          <= fifo_len - 1;
    end else if (!bus.out_fifo_empty) begin
      if (drain_cnt == 0) bus.out_fifo_empty <= 1'b1;
      else drain_cnt <= drain_cnt - 1;
    end
  end

  // Trigger/done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.lfsr_pulse_trigger || bus.lfsr_shift_trigger) begin
        byte op;
        chk("trig_excl", int'(bus.lfsr_pulse_trigger && bus.lfsr_shift_trigger), 0);
        op = bus.lfsr_shift_trigger ? "S" : "P";
        if (bus.lfsr_shift_trigger) begin
          s_cnt++;
          chk("shift_empty", int'(bus.out_fifo_empty), 1);
        end else begin
          p_cnt++;
        end
        if (chk_spacing && last_trig_cyc >= 0)
          chk("trig_space", int'((cyc - last_trig_cyc - 1) >= 2), 1);
        last_trig_cyc = cyc;
        if (exp_q.size() == 0) chk("extra_trig", int'(op), 0);
        else chk("trig_order", int'(op), int'(exp_q.pop_front()));
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_batch(input int n, input logic [1:0] m, input int g);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      case (m)
        SEQ_MODE_PULSE: exp_q.push_back("P");
        SEQ_MODE_SHIFT: exp_q.push_back("S");
        SEQ_MODE_P_S:   begin exp_q.push_back("P"); exp_q.push_back("S"); end
        default:        begin exp_q.push_back("S"); exp_q.push_back("P"); end
      endcase
    end
    p_cnt = 0; s_cnt = 0; done_cnt = 0; last_trig_cyc = -1;
    bus.num_iter   = 16'(n);
    bus.mode       = m;
    bus.gap_cycles = 8'(g);
    bus.start      = 1'b1;
    start_cyc      = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    @(negedge clk);
    $display("[TB] batch n=%0d mode=%b: P=%0d S=%0d iter_count=%0d aborted=%0b seq_error=%0b",
             bus.num_iter, bus.mode, p_cnt, s_cnt, bus.iter_count, bus.aborted, bus.seq_error);
  endtask

  task automatic wait_cond_shift(input int target, input int budget);
    int k = 0;
    while (s_cnt < target && k < budget) begin @(negedge clk); k++; end
    if (s_cnt < target) chk("shift_wait_timeout", s_cnt, target);
  endtask

  task automatic wait_cond_pulse(input int target, input int budget);
    int k = 0;
    while (p_cnt < target && k < budget) begin @(negedge clk); k++; end
    if (p_cnt < target) chk("pulse_wait_timeout", p_cnt, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.num_iter = '0; bus.mode = '0; bus.gap_cycles = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  int'(bus.busy), 0);
    chk("rst_done",  int'(bus.done), 0);
    chk("rst_ptrig", int'(bus.lfsr_pulse_trigger), 0);
    chk("rst_strig", int'(bus.lfsr_shift_trigger), 0);
    chk("rst_abrt",  int'(bus.aborted), 0);
    chk("rst_err",   int'(bus.seq_error), 0);
    chk("rst_iter",  int'(bus.iter_count), 0);
    rst = 1'b0;

    // Pulse-only batch with inter-iteration gap.
    ctrl_len = 10; fifo_len = 0; chk_spacing = 1'b1;
    start_batch(3, SEQ_MODE_PULSE, 2);
    wait_done(1000);
    chk_spacing = 1'b0;
    chk("t1_pulses", p_cnt, 3);
    chk("t1_shifts", s_cnt, 0);
    chk("t1_iter",   int'(bus.iter_count), 3);
    chk("t1_busy",   int'(bus.busy), 0);
    chk("t1_abrt",   int'(bus.aborted), 0);
    chk("t1_q",      exp_q.size(), 0);

    // Pulse->shift with slow host drain.
    fifo_len = 50;
    start_batch(2, SEQ_MODE_P_S, 0);
    wait_done(2000);
    chk("t2_pulses", p_cnt, 2);
    chk("t2_shifts", s_cnt, 2);
    chk("t2_iter",   int'(bus.iter_count), 2);
    chk("t2_q",      exp_q.size(), 0);

    // Empty batch.
    fifo_len = 0;
    start_batch(0, SEQ_MODE_S_P, 1);
    wait_done(20);
    chk("t3_latency", done_cyc - start_cyc, 2);
    chk("t3_trigs",   p_cnt + s_cnt, 0);
    chk("t3_iter",    int'(bus.iter_count), 0);

    // Abort during the second op's controller run.
    start_batch(5, SEQ_MODE_SHIFT, 3);
    wait_cond_shift(2, 500);
    repeat (4) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    wait_done(500);
    chk("t4_abrt",  int'(bus.aborted), 1);
    chk("t4_iter",  int'(bus.iter_count), 1);
    chk("t4_left",  exp_q.size(), 3);
    exp_q.delete();
    repeat (20) @(negedge clk);
    chk("t4_shifts", s_cnt, 2);
    chk("t4_pulses", p_cnt, 0);

    // Controller never acknowledges.
    hang = 1'b1;
    start_batch(1, SEQ_MODE_PULSE, 0);
`ifdef SEQ_WATCHDOG_EN
    wait_done(100);
    chk("t5_latency", done_cyc - last_trig_cyc, 16);
    chk("t5_err",     int'(bus.seq_error), 1);
    chk("t5_abrt",    int'(bus.aborted), 0);
    chk("t5_iter",    int'(bus.iter_count), 0);
`else
    repeat (200) @(negedge clk);
    chk("t5_busy",  int'(bus.busy), 1);
    chk("t5_ndone", done_cnt, 0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    wait_done(50);
    chk("t5_abrt", int'(bus.aborted), 1);
    chk("t5_err",  int'(bus.seq_error), 0);
`endif
    hang = 1'b0;
    chk("t5_q", exp_q.size(), 0);

    // Reset in the middle of a gap, then a clean batch.
    ctrl_len = 5;
    start_batch(4, SEQ_MODE_PULSE, 20);
    wait_cond_pulse(1, 200);
    repeat (12) @(negedge clk);
    chk("t6_pre_busy", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    chk("t6_busy",  int'(bus.busy), 0);
    chk("t6_done",  int'(bus.done), 0);
    chk("t6_iter",  int'(bus.iter_count), 0);
    chk("t6_ptrig", int'(bus.lfsr_pulse_trigger), 0);
    chk("t6_strig", int'(bus.lfsr_shift_trigger), 0);
    repeat (3) @(negedge clk);
    chk("t6_ndone", done_cnt, 0);
    rst = 1'b0;
    exp_q.delete();
    fifo_len = 3;
    start_batch(2, SEQ_MODE_S_P, 0);
    wait_done(1000);
    chk("t6_pulses", p_cnt, 2);
    chk("t6_shifts", s_cnt, 2);
    chk("t6_iter2",  int'(bus.iter_count), 2);
    chk("t6_q",      exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
